// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory side.
//   opcode     : instruction[6:0] from the instruction register (datapath -> ctrl)
//   zero       : ALU zero flag (datapath -> ctrl)
//   mem_ready  : memory accepts/completes the current request (memory -> ctrl)
//   mem_req, mem_write, adr_src                  : memory port control (ctrl -> memory)
//   ir_write, pc_write, reg_write                : datapath write enables (ctrl -> datapath)
//   alu_src_a, alu_src_b, result_src, alu_op     : datapath mux selects / ALU class
//   fault      : sticky illegal-opcode / memory-timeout indication
// master = the control FSM, slave = datapath/memory side.
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       fault;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        output alu_src_a, alu_src_b, result_src, alu_op, fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        input  alu_src_a, alu_src_b, result_src, alu_op, fault
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control state machine for a multicycle RV32I core (lw, sw, R-type, I-type ALU, beq,
// jal). Sequences the shared ALU, register file and unified memory port, stalls on the
// mem_req/mem_ready handshake and drops into a sticky FAULT state on an illegal opcode or a
// memory request that waits too long.
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset (forces IDLE, drops any in-flight request)
//   bus_io  : control bundle, master side (see multicycle_ctrl_fsm_if)
// Parameters:
//   TIMEOUT_CYCLES : max cycles a memory request may wait for mem_ready (>= 1)
//   CNT_W          : watchdog width, 2**CNT_W must exceed TIMEOUT_CYCLES
module multicycle_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_fsm_if.master  bus_io
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic       req_state;
    logic       pc_update;
    logic       branch;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       fault;

    // States that own the memory port and are therefore watched by the watchdog.
    assign req_state = (state_q == StFetch) || (state_q == StMemRead) ||
                       (state_q == StMemWrite);

    // Next-state and watchdog.
    always_comb begin
        state_d = state_q;
        wdog_d  = '0;
        unique case (state_q)
            StIdle:     state_d = StFetch;
            StFetch:    if (bus_io.mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (bus_io.opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StFault;
                endcase
            end
            StMemAdr:   state_d = (bus_io.opcode == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  if (bus_io.mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (bus_io.mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StFault:    state_d = StFault;
            default:    state_d = StFault;
        endcase

        // A stalled request either counts up or is abandoned once its budget is spent.
        if (req_state && !bus_io.mem_ready) begin
            if (wdog_q == WdogLast) begin
                state_d = StFault;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
        end
    end

    // Outputs decoded from the registered state so an async reset removes them at once.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        fault      = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // IR and PC advance only in the cycle the fetch completes.
                ir_write   = bus_io.mem_ready;
                pc_update  = bus_io.mem_ready;
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            StAluWb: reg_write = 1'b1;
            StBeq: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            StFault: fault = 1'b1;
            default: ;
        endcase
    end

    assign bus_io.mem_req    = mem_req;
    assign bus_io.mem_write  = mem_write;
    assign bus_io.adr_src    = adr_src;
    assign bus_io.ir_write   = ir_write;
    assign bus_io.pc_write   = pc_update | (branch & bus_io.zero);
    assign bus_io.reg_write  = reg_write;
    assign bus_io.alu_src_a  = alu_src_a;
    assign bus_io.alu_src_b  = alu_src_b;
    assign bus_io.result_src = result_src;
    assign bus_io.alu_op     = alu_op;
    assign bus_io.fault      = fault;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm. Output vector packing:
// {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
//  alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], alu_op[1:0], fault}
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBad    = 7'b1111111;

    //                                       rq wr ad ir pc rw  a  b  res op f
    localparam logic [14:0] VIdle      = 15'b0__0__0__0__0__0__00_00_00_00_0;
    localparam logic [14:0] VFetchWait = 15'b1__0__0__0__0__0__00_10_10_00_0;
    localparam logic [14:0] VFetchGo   = 15'b1__0__0__1__1__0__00_10_10_00_0;
    localparam logic [14:0] VDecode    = 15'b0__0__0__0__0__0__01_01_00_00_0;
    localparam logic [14:0] VMemAdr    = 15'b0__0__0__0__0__0__10_01_00_00_0;
    localparam logic [14:0] VMemRead   = 15'b1__0__1__0__0__0__00_00_00_00_0;
    localparam logic [14:0] VMemWb     = 15'b0__0__0__0__0__1__00_00_01_00_0;
    localparam logic [14:0] VMemWrite  = 15'b1__1__1__0__0__0__00_00_00_00_0;
    localparam logic [14:0] VExecR     = 15'b0__0__0__0__0__0__10_00_00_10_0;
    localparam logic [14:0] VExecI     = 15'b0__0__0__0__0__0__10_01_00_10_0;
    localparam logic [14:0] VAluWb     = 15'b0__0__0__0__0__1__00_00_00_00_0;
    localparam logic [14:0] VBeqTaken  = 15'b0__0__0__0__1__0__10_00_00_01_0;
    localparam logic [14:0] VBeqNot    = 15'b0__0__0__0__0__0__10_00_00_01_0;
    localparam logic [14:0] VJal       = 15'b0__0__0__0__1__0__01_10_00_00_0;
    localparam logic [14:0] VFault     = 15'b0__0__0__0__0__0__00_00_00_00_1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] observed();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op,
                bus.fault};
    endfunction

    task automatic chk(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs for one cycle, check the outputs of the current state, then advance.
    task automatic cyc(input logic rdy, input logic z, input string tag,
                       input logic [14:0] exp);
        bus.mem_ready = rdy;
        bus.zero      = z;
        #1;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_async"}, VIdle);
        @(posedge clk);
        #1;
        chk({tag, "_held"}, VIdle);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_rel"}, VIdle);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = OpRType;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_idle", VIdle);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_idle", VIdle);
        @(posedge clk);
        #1;

        // R-type, no stalls
        cyc(1'b1, 1'b0, "r_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "r_decode", VDecode);
        cyc(1'b1, 1'b0, "r_exec", VExecR);
        cyc(1'b1, 1'b0, "r_wb", VAluWb);

        // lw: 3 FETCH stalls (last one at the watchdog boundary), 2 MEMREAD stalls
        bus.opcode = OpLoad;
        cyc(1'b0, 1'b0, "lw_fetch_w0", VFetchWait);
        cyc(1'b0, 1'b0, "lw_fetch_w1", VFetchWait);
        cyc(1'b0, 1'b0, "lw_fetch_w2", VFetchWait);
        cyc(1'b1, 1'b0, "lw_fetch_go", VFetchGo);
        cyc(1'b1, 1'b0, "lw_decode", VDecode);
        cyc(1'b1, 1'b0, "lw_memadr", VMemAdr);
        cyc(1'b0, 1'b0, "lw_read_w0", VMemRead);
        cyc(1'b0, 1'b0, "lw_read_w1", VMemRead);
        cyc(1'b1, 1'b0, "lw_read_go", VMemRead);
        cyc(1'b1, 1'b0, "lw_memwb", VMemWb);

        // beq taken, then not taken
        bus.opcode = OpBranch;
        cyc(1'b1, 1'b0, "beq1_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "beq1_decode", VDecode);
        cyc(1'b0, 1'b1, "beq1_taken", VBeqTaken);
        cyc(1'b1, 1'b0, "beq2_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "beq2_decode", VDecode);
        cyc(1'b0, 1'b0, "beq2_not", VBeqNot);

        // I-type
        bus.opcode = OpIType;
        cyc(1'b1, 1'b0, "i_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "i_decode", VDecode);
        cyc(1'b1, 1'b0, "i_exec", VExecI);
        cyc(1'b1, 1'b0, "i_wb", VAluWb);

        // jal
        bus.opcode = OpJal;
        cyc(1'b1, 1'b0, "jal_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "jal_decode", VDecode);
        cyc(1'b1, 1'b0, "jal_exec", VJal);
        cyc(1'b1, 1'b0, "jal_wb", VAluWb);

        // sw completing immediately
        bus.opcode = OpStore;
        cyc(1'b1, 1'b0, "sw_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "sw_decode", VDecode);
        cyc(1'b1, 1'b0, "sw_memadr", VMemAdr);
        cyc(1'b1, 1'b0, "sw_write", VMemWrite);

        // sw with mem_ready stuck low: 4 request cycles then FAULT
        cyc(1'b1, 1'b0, "swto_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "swto_decode", VDecode);
        cyc(1'b1, 1'b0, "swto_memadr", VMemAdr);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "swto_wait", VMemWrite);
        cyc(1'b0, 1'b0, "swto_fault", VFault);
        cyc(1'b1, 1'b1, "swto_fault_sticky", VFault);
        reset_pulse("swto_rst");

        // FETCH timeout
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "fetchto_wait", VFetchWait);
        cyc(1'b0, 1'b0, "fetchto_fault", VFault);
        reset_pulse("fetchto_rst");

        // Illegal opcode: FAULT for 20 cycles regardless of inputs
        bus.opcode = OpBad;
        cyc(1'b1, 1'b0, "bad_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "bad_decode", VDecode);
        for (int i = 0; i < 20; i++) cyc(i[0], i[1], "bad_fault", VFault);
        reset_pulse("bad_rst");

        // Async reset during a MEMWRITE wait
        bus.opcode = OpStore;
        cyc(1'b1, 1'b0, "rstw_fetch", VFetchGo);
        cyc(1'b1, 1'b0, "rstw_decode", VDecode);
        cyc(1'b1, 1'b0, "rstw_memadr", VMemAdr);
        cyc(1'b0, 1'b0, "rstw_wait0", VMemWrite);
        #2;
        chk("rstw_wait1", VMemWrite);
        rst_n = 1'b0;
        #1;
        chk("rstw_async_drop", VIdle);
        @(posedge clk);
        #1;
        chk("rstw_held", VIdle);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstw_rel", VIdle);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, "rstw_fetch_again", VFetchWait);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
